// File: rtl/kgp_rf_pkg.sv
// rtl/kgp_rf_pkg.sv - shared defaults, typedefs and zero-register helper for the KGP register file
// Optional macro KGP_RF_ZERO_REG_EN hardwires register 0 to zero.
package kgp_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // True when an access to this address must behave as the hardwired zero register.
  function automatic logic rf_zero_fwd(input logic i_is_zero_addr);
`ifdef KGP_RF_ZERO_REG_EN
    return i_is_zero_addr;
`else
    return 1'b0 & i_is_zero_addr;
`endif
  endfunction

endpackage

// File: rtl/kgp_rf_scoreboard.sv
// rtl/kgp_rf_scoreboard.sv - pending-write scoreboard, pending counter and per-port busy flags
// Honours KGP_RF_ZERO_REG_EN through rf_zero_fwd: register 0 is never marked pending.
module kgp_rf_scoreboard
  import kgp_rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             w_inc;
  logic             w_dec;

  assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !rf_zero_fwd(wr_addr == '0);
  assign w_iss_ok = iss_en && ({1'b0, iss_addr} < DEPTH_L) && !rf_zero_fwd(iss_addr == '0);

  // A same-address issue overrides the writeback clear: the new producer is still outstanding.
  assign w_inc = w_iss_ok && !r_pend[iss_addr];
  assign w_dec = w_wr_ok && r_pend[wr_addr] && !(w_iss_ok && (iss_addr == wr_addr));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) w_pend_nxt[wr_addr] = 1'b0;
    if (w_iss_ok) w_pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + (ADDR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (ADDR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pend_cnt = r_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] w_addr;
    logic              w_ok;
    assign w_addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_ok       = ({1'b0, w_addr} < DEPTH_L);
    assign rd_busy[k] = w_ok && r_pend[w_addr] && !(w_wr_ok && (wr_addr == w_addr));
  end

endmodule

// File: rtl/kgp_regfile_sb.sv
// rtl/kgp_regfile_sb.sv - multi-port register file with write-first bypass and pending-write scoreboard
// Optional macro KGP_RF_ZERO_REG_EN hardwires register 0 to zero.
module kgp_regfile_sb
  import kgp_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic              w_wr_ok;

  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !rf_zero_fwd(wr_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_ok;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_ok   = ({1'b0, w_addr} < DEPTH_L) && !rf_zero_fwd(w_addr == '0);
    // Write-first: a same-cycle writeback to this address is forwarded ahead of the array.
    assign rd_data[k*DATA_W +: DATA_W] = !w_ok                          ? '0 :
                                         (w_wr_ok && wr_addr == w_addr) ? wr_data :
                                                                          r_rf[w_addr];
  end

  kgp_rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_busy  (rd_busy),
    .pend_cnt (pend_cnt)
  );

endmodule
